// File: rtl/mips_dbg_pkg.sv
// Shared encodings and default checker constants for the MIPS debug monitor,
// reused by the RTL, the bench and the FPGA top.
package mips_dbg_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_PASS    = 2'b01,
        ST_FAIL    = 2'b10,
        ST_TIMEOUT = 2'b11
    } mon_state_e;

    localparam logic [31:0] DEF_PASS_ADDR      = 32'd84;
    localparam logic [31:0] DEF_PASS_DATA      = 32'd7;
    localparam logic [31:0] DEF_IGNORE_ADDR    = 32'd80;
    localparam int          DEF_TIMEOUT_CYCLES = 1000;

    function automatic logic is_terminal(input mon_state_e s);
        return (s != ST_RUN);
    endfunction

endpackage

// File: rtl/cycle_watchdog.sv
// Counts enabled cycles since reset and flags the cycle on which the
// TIMEOUT_CYCLES budget runs out.
module cycle_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Holding at LAST keeps the counter from wrapping if enable stays high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (enable && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = enable && (r_count == LAST);

endmodule

// File: rtl/store_monitor.sv
// Watches the MIPS data-memory write bus and decides PASS, FAIL or TIMEOUT;
// keeps sticky status plus store statistics for a bench or LEDs.
module store_monitor
    import mips_dbg_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR      = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_DATA      = DEF_PASS_DATA,
    parameter logic [31:0] IGNORE_ADDR    = DEF_IGNORE_ADDR,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [31:0]      dataadr,
    input  logic [31:0]      writedata,
    output logic [1:0]       status,
    output logic             done,
    output logic [CNT_W-1:0] store_count,
    output logic [31:0]      last_adr,
    output logic [31:0]      last_data
);

    mon_state_e       r_state;
    mon_state_e       w_next_state;
    logic             w_accept;
    logic             w_run;
    logic             w_expired;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_last_adr;
    logic [31:0]      r_last_data;

    assign w_run = (r_state == ST_RUN);

    cycle_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .enable (w_run),
        .expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A deciding store beats the timeout; an ignored store does not.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        if (r_state == ST_RUN) begin
            w_accept = memwrite;
            if (memwrite && (dataadr == PASS_ADDR) && (writedata == PASS_DATA)) begin
                w_next_state = ST_PASS;
            end else if (memwrite && (dataadr != IGNORE_ADDR)) begin
                w_next_state = ST_FAIL;
            end else if (w_expired) begin
                w_next_state = ST_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_last_adr  <= '0;
            r_last_data <= '0;
        end else if (w_accept) begin
            r_last_adr  <= dataadr;
            r_last_data <= writedata;
            if (r_count != {CNT_W{1'b1}}) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign status      = r_state;
    assign done        = is_terminal(r_state);
    assign store_count = r_count;
    assign last_adr    = r_last_adr;
    assign last_data   = r_last_data;

endmodule

// File: tb/tb_store_monitor.sv
// Self-checking bench for store_monitor: directed scenarios plus randomized
// store traffic checked against a rule-level reference model.
module tb_store_monitor;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;

    // Instance a: default parameters. Instance b: short timeout, 2-bit counter.
    logic [1:0]  status_a, status_b;
    logic        done_a, done_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
    logic [31:0] ladr_a, ladr_b, ldat_a, ldat_b;

    int errors = 0;
    int checks = 0;

    store_monitor dut_a (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .status     (status_a),
        .done       (done_a),
        .store_count(cnt_a),
        .last_adr   (ladr_a),
        .last_data  (ldat_a)
    );

    store_monitor #(
        .TIMEOUT_CYCLES(10),
        .CNT_W         (2)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .status     (status_b),
        .done       (done_b),
        .store_count(cnt_b),
        .last_adr   (ladr_b),
        .last_data  (ldat_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: outcome 0 running, 1 pass, 2 fail, 3 timeout.
    int          lim[2]  = '{1000, 10};
    longint      cmax[2] = '{65535, 3};
    int          m_st[2];
    int          m_edges[2];
    longint      m_cnt[2];
    logic [31:0] m_adr[2];
    logic [31:0] m_dat[2];

    task automatic model_edge(input logic rst, input logic w, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_st[i] = 0; m_edges[i] = 0; m_cnt[i] = 0; m_adr[i] = 0; m_dat[i] = 0;
            end else if (m_st[i] == 0) begin
                m_edges[i]++;
                if (w) begin
                    m_adr[i] = a;
                    m_dat[i] = d;
                    if (m_cnt[i] < cmax[i]) m_cnt[i]++;
                    if (a == 32'd84 && d == 32'd7) m_st[i] = 1;
                    else if (a != 32'd80)          m_st[i] = 2;
                end
                if (m_st[i] == 0 && m_edges[i] == lim[i]) m_st[i] = 3;
            end
        end
    endtask

    // Driver: inputs change on negedge, model advances on posedge, sample 1ns later.
    task automatic tick(input logic rst, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reset = rst; memwrite = w; dataadr = a; writedata = d;
        @(posedge clk);
        model_edge(rst, w, a, d);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_reset;
        do_reset(3);
        checks++; if (status_a !== 2'b00) begin errors++; $display("FAIL reset_status got=%0d want=0", status_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b want=0", done_a); end
        checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", cnt_a); end
        checks++; if (ladr_a !== 32'd0 || ldat_a !== 32'd0) begin errors++; $display("FAIL reset_capture got=%0d/%0d want=0/0", ladr_a, ldat_a); end
        checks++; if (status_b !== 2'b00 || cnt_b !== 2'd0) begin errors++; $display("FAIL reset_b got=%0d/%0d want=0/0", status_b, cnt_b); end
    endtask

    task automatic test_pass;
        tick(1'b0, 1'b1, 32'd80, 32'h12);
        checks++; if (status_a !== 2'b00) begin errors++; $display("FAIL pass_ignore_run got=%0d want=0", status_a); end
        tick(1'b0, 1'b1, 32'd84, 32'd7);
        checks++; if (status_a !== 2'b01 || done_a !== 1'b1) begin errors++; $display("FAIL pass_status got=%0d/%0b want=1/1", status_a, done_a); end
        checks++; if (cnt_a !== 16'd2) begin errors++; $display("FAIL pass_count got=%0d want=2", cnt_a); end
        checks++; if (ladr_a !== 32'd84 || ldat_a !== 32'd7) begin errors++; $display("FAIL pass_capture got=%0d/%0d want=84/7", ladr_a, ldat_a); end
        tick(1'b0, 1'b1, 32'd100, 32'd5);
        idle(2);
        checks++; if (status_a !== 2'b01 || cnt_a !== 16'd2 || ladr_a !== 32'd84 || ldat_a !== 32'd7) begin
            errors++; $display("FAIL pass_sticky got st=%0d cnt=%0d adr=%0d dat=%0d want 1/2/84/7", status_a, cnt_a, ladr_a, ldat_a);
        end
    endtask

    task automatic test_fail;
        do_reset(1);
        tick(1'b0, 1'b1, 32'd84, 32'd6);
        checks++; if (status_a !== 2'b10 || done_a !== 1'b1) begin errors++; $display("FAIL fail_data_status got=%0d/%0b want=2/1", status_a, done_a); end
        checks++; if (ldat_a !== 32'd6 || cnt_a !== 16'd1) begin errors++; $display("FAIL fail_data_capture got=%0d/%0d want=6/1", ldat_a, cnt_a); end
        do_reset(1);
        tick(1'b0, 1'b1, 32'd88, 32'd7);
        checks++; if (status_a !== 2'b10) begin errors++; $display("FAIL fail_addr_status got=%0d want=2", status_a); end
        checks++; if (ladr_a !== 32'd88) begin errors++; $display("FAIL fail_addr_capture got=%0d want=88", ladr_a); end
    endtask

    task automatic test_timeout;
        do_reset(1);
        idle(9);
        checks++; if (done_b !== 1'b0 || status_b !== 2'b00) begin errors++; $display("FAIL timeout_early got=%0b/%0d want=0/0", done_b, status_b); end
        idle(1);
        checks++; if (done_b !== 1'b1 || status_b !== 2'b11) begin errors++; $display("FAIL timeout_edge got=%0b/%0d want=1/3", done_b, status_b); end
        checks++; if (cnt_b !== 2'd0) begin errors++; $display("FAIL timeout_count got=%0d want=0", cnt_b); end
        checks++; if (status_a !== 2'b00) begin errors++; $display("FAIL timeout_a_running got=%0d want=0", status_a); end
    endtask

    task automatic test_simultaneous;
        do_reset(1);
        idle(9);
        tick(1'b0, 1'b1, 32'd84, 32'd7);
        checks++; if (status_b !== 2'b01) begin errors++; $display("FAIL simul_pass got=%0d want=1", status_b); end
        do_reset(1);
        idle(9);
        tick(1'b0, 1'b1, 32'd80, 32'd1);
        checks++; if (status_b !== 2'b11) begin errors++; $display("FAIL simul_ignore_status got=%0d want=3", status_b); end
        checks++; if (cnt_b !== 2'd1 || ladr_b !== 32'd80 || ldat_b !== 32'd1) begin
            errors++; $display("FAIL simul_ignore_capture got=%0d/%0d/%0d want=1/80/1", cnt_b, ladr_b, ldat_b);
        end
        do_reset(1);
        idle(9);
        tick(1'b0, 1'b1, 32'd84, 32'd8);
        checks++; if (status_b !== 2'b10) begin errors++; $display("FAIL simul_fail got=%0d want=2", status_b); end
    endtask

    task automatic test_saturation;
        do_reset(1);
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 32'd80, 32'(k));
        checks++; if (cnt_b !== 2'd3 || status_b !== 2'b00) begin errors++; $display("FAIL sat_b got=%0d/%0d want=3/0", cnt_b, status_b); end
        checks++; if (cnt_a !== 16'd5) begin errors++; $display("FAIL sat_a got=%0d want=5", cnt_a); end
        checks++; if (ldat_b !== 32'd4) begin errors++; $display("FAIL sat_last_data got=%0d want=4", ldat_b); end
    endtask

    task automatic test_reset_terminal;
        do_reset(1);
        tick(1'b0, 1'b1, 32'd88, 32'd3);
        checks++; if (status_a !== 2'b10) begin errors++; $display("FAIL rst_term_setup got=%0d want=2", status_a); end
        do_reset(1);
        checks++; if (status_a !== 2'b00 || done_a !== 1'b0 || cnt_a !== 16'd0 || ladr_a !== 32'd0 || ldat_a !== 32'd0) begin
            errors++; $display("FAIL rst_term got st=%0d done=%0b cnt=%0d adr=%0d dat=%0d want all 0", status_a, done_a, cnt_a, ladr_a, ldat_a);
        end
        tick(1'b0, 1'b1, 32'd80, 32'd9);
        tick(1'b0, 1'b1, 32'd80, 32'd10);
        do_reset(1);
        checks++; if (cnt_a !== 16'd0 || ladr_a !== 32'd0 || ldat_a !== 32'd0) begin
            errors++; $display("FAIL rst_midrun got cnt=%0d adr=%0d dat=%0d want 0/0/0", cnt_a, ladr_a, ldat_a);
        end
        // Watchdog must also restart: a fresh 10-cycle budget on b.
        idle(9);
        checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL rst_watchdog got=%0b want=0", done_b); end
        idle(1);
        checks++; if (status_b !== 2'b11) begin errors++; $display("FAIL rst_watchdog_to got=%0d want=3", status_b); end
    endtask

    // Store trace of the self-checking MIPS test program, bounded to 100 cycles.
    task automatic test_program;
        int found;
        found = 0;
        do_reset(1);
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (c == 14)      tick(1'b0, 1'b1, 32'd80, 32'd7);
            else if (c == 17) tick(1'b0, 1'b1, 32'd84, 32'd7);
            else              idle(1);
            if (done_a === 1'b1) found = c + 1;
        end
        checks++; if (found == 0) begin errors++; $display("FAIL program_done got=not_done want=done_within_100"); end
        checks++; if (status_a !== 2'b01 || cnt_a !== 16'd2) begin errors++; $display("FAIL program_pass got=%0d/%0d want=1/2", status_a, cnt_a); end
        checks++; if (found != 18) begin errors++; $display("FAIL program_latency got=%0d want=18", found); end
    endtask

    task automatic test_random;
        logic        w;
        logic [31:0] a, d;
        logic [31:0] cnt_o[2];
        logic [1:0]  st_o[2];
        logic        dn_o[2];
        logic [31:0] adr_o[2];
        logic [31:0] dat_o[2];
        for (int run = 0; run < 40; run++) begin
            do_reset(1);
            for (int t = 0; t < 25; t++) begin
                w = ($urandom_range(0, 2) == 0);
                case ($urandom_range(0, 9))
                    6, 9:    a = 32'd84;
                    7:       a = 32'd88;
                    8:       a = $urandom;
                    default: a = 32'd80;
                endcase
                d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(5, 8));
                if ($urandom_range(0, 39) == 0) tick(1'b1, w, a, d);
                else                            tick(1'b0, w, a, d);
                st_o[0] = status_a; dn_o[0] = done_a; cnt_o[0] = 32'(cnt_a); adr_o[0] = ladr_a; dat_o[0] = ldat_a;
                st_o[1] = status_b; dn_o[1] = done_b; cnt_o[1] = 32'(cnt_b); adr_o[1] = ladr_b; dat_o[1] = ldat_b;
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (st_o[i] !== 2'(m_st[i]) || dn_o[i] !== (m_st[i] != 0) || cnt_o[i] !== 32'(m_cnt[i])
                        || adr_o[i] !== m_adr[i] || dat_o[i] !== m_dat[i]) begin
                        errors++;
                        $display("FAIL random dut=%0d run=%0d t=%0d got st=%0d dn=%0b cnt=%0d adr=%0h dat=%0h want st=%0d cnt=%0d adr=%0h dat=%0h",
                                 i, run, t, st_o[i], dn_o[i], cnt_o[i], adr_o[i], dat_o[i], m_st[i], m_cnt[i], m_adr[i], m_dat[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_simultaneous();
        test_saturation();
        test_reset_terminal();
        test_program();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_monitor.md
Name: store_monitor

Overview:
- Synthesizable checker that sits directly downstream of the single-cycle MIPS top level.
- Consumes its data-memory write bus (memwrite, dataadr, writedata) and decides pass, fail or timeout for self-checking programs.
- Produces sticky status flags and store statistics for the bench, FPGA LEDs or a debug readout.
- Replaces negedge bench-only checking with a posedge, cycle-accurate state machine.

Parameters:
- PASS_ADDR, 32'd84: store address that, with PASS_DATA, ends the run successfully.
- PASS_DATA, 32'd7: data value required at PASS_ADDR for success.
- IGNORE_ADDR, 32'd80: store address treated as benign scratch traffic.
- TIMEOUT_CYCLES, 1000: cycles allowed after reset release before declaring timeout (must be ≥ 2).
- CNT_W, 16: width of store_count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; shared with the processor.
- memwrite  in  1  data-memory write strobe from the processor.
- dataadr  in  32  data-memory byte address.
- writedata  in  32  data-memory write data.
- status  out  2  00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT.
- done  out  1  high in any terminal state (PASS, FAIL or TIMEOUT).
- store_count  out  CNT_W  number of stores accepted while in RUN; saturates at all-ones.
- last_adr  out  32  address of the most recent store accepted in RUN.
- last_data  out  32  data of the most recent store accepted in RUN.

Behaviour:
- Reset (sampled high at the edge):
  - state goes to RUN; status = 00, done = 0.
  - store_count, last_adr, last_data and the cycle counter go to 0.
  - Applies equally mid-run or from any terminal state: one reset edge fully restarts.
- RUN, each rising edge with reset low:
  - The cycle counter increments.
  - If memwrite = 1, the store is accepted: last_adr/last_data capture dataadr/writedata, and store_count increments unless it is at all-ones.
  - If dataadr == PASS_ADDR and writedata == PASS_DATA, go to PASS.
  - Else if dataadr != IGNORE_ADDR, go to FAIL. This includes PASS_ADDR carrying wrong data.
  - Else (dataadr == IGNORE_ADDR), stay in RUN.
  - If no store decided the state and the counter equals TIMEOUT_CYCLES-1, go to TIMEOUT.
- Simultaneous events:
  - A store on the timeout edge takes priority: its PASS/FAIL decision wins.
  - An IGNORE_ADDR store on the timeout edge still yields TIMEOUT; that store is counted and captured.
- Latency:
  - Flags are decoded from registered state and are visible immediately after the deciding edge (1-cycle latency from the sampled store).
  - Earliest timeout: done rises after edge number TIMEOUT_CYCLES following reset release.
- Terminal states (PASS, FAIL, TIMEOUT):
  - Sticky until reset.
  - memwrite is ignored; store_count, last_adr, last_data and the cycle counter freeze.
- Compare and width rules:
  - Compares are full 32-bit equality; no masking of low address bits.
  - The cycle counter is $clog2(TIMEOUT_CYCLES) bits wide and never wraps, since it stops at the terminal state.
- Out of scope: X/Z on the inputs; the processor guarantees known values while reset is low.

Decomposition:
- Shared package mips_dbg_pkg:
  - state/status encoding enum (RUN, PASS, FAIL, TIMEOUT as 2-bit values).
  - default constants for PASS_ADDR, PASS_DATA, IGNORE_ADDR and TIMEOUT_CYCLES, for reuse by bench and FPGA top.
- One sub-module, cycle_watchdog:
  - inputs: clk, reset, enable (state == RUN).
  - output: expired pulse when the count hits TIMEOUT_CYCLES-1.
  - parameterized by TIMEOUT_CYCLES.
- store_monitor holds the FSM, the capture registers and the saturating counter.

Test Plan:
1. Pass path: reset high for 3 edges, then stores (80,0x12) and (84,7) on consecutive cycles → status 01, done = 1, store_count = 2, last_adr = 84, last_data = 7; a later store (100,5) changes nothing.
2. Fail on wrong data: store (84,6) → status 10, last_data = 6, store_count = 1. Fail on stray address: store (88,7) → status 10.
3. Timeout: TIMEOUT_CYCLES = 10, no memwrite → done rises exactly after the 10th edge following reset release, status 11, store_count = 0.
4. Simultaneous events (TIMEOUT_CYCLES = 10): store (84,7) on the 10th edge → PASS, not TIMEOUT. Store (80,1) on that edge → TIMEOUT with store_count = 1.
5. Saturation: CNT_W = 2, five stores to 80 → store_count stays 3, status 00.
6. Reset mid-run and from a terminal state: force FAIL, assert reset for 1 edge → status 00, all counters and capture registers 0. Then run the full 18-instruction program on Top → PASS within 100 cycles.
